ifft_reorder: RTL
=================

# ifft_reorder

Transmit-path stage between the IFFT core and the cyclic-prefix inserter. Takes IFFT output samples in bit-reversed order and scales them (round, then saturate) to 8-bit signed. Stores each symbol in one half of a ping-pong buffer. Emits each 64-sample symbol in natural order as a contiguous burst with a 6-bit sample index, which is the input format the CP stage needs.

## Interface
Parameters:
- DIN_W, 16: input sample width, signed two's complement.
- SHIFT, 6: right-shift applied before saturation to 8 bits; must be 1..DIN_W-1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- Din_Re  in  DIN_W  IFFT real output, signed.
- Din_Im  in  DIN_W  IFFT imaginary output, signed.
- Din_En  in  1  input sample valid.
- Din_Rdy  out  1  buffer can accept a sample; a transfer occurs when Din_En & Din_Rdy.
- Dout_Re  out  8  reordered real sample, signed.
- Dout_Im  out  8  reordered imaginary sample, signed.
- Dout_En  out  1  output sample valid.
- Dout_Index  out  6  natural-order index 0..63 of the output sample.
- Sat  out  1  one-cycle pulse when either component of an accepted sample saturated.

## Operation
- Scaling per component:
  - y = (x + 2^(SHIFT-1)) >>> SHIFT, computed at DIN_W+1 bits (round half up).
  - Then clamp y to [-128, 127].
  - Sat is the registered OR of the Re and Im clamp events; it asserts the cycle after the transfer.
- Write side:
  - wr_cnt (6 bit) counts accepted samples.
  - Sample k is stored at address bitrev6(wr_cnt) of bank wr_bank.
  - On k=63: set full[wr_bank], toggle wr_bank, clear wr_cnt.
- Din_Rdy = ~full[wr_bank], registered-equivalent with no combinational path from Din_En.
- Read-side FSM states:
  - IDLE: go to RUN when full[rd_bank] is set.
  - RUN: issue rd_addr 0..63 on consecutive cycles. When rd_addr=63 is issued:
    - clear full[rd_bank] (takes effect the next cycle);
    - toggle rd_bank;
    - if full of the new rd_bank is already set, stay in RUN and issue rd_addr 0 next cycle, giving no output gap;
    - otherwise go to IDLE.
- Output: RAM read is one cycle. Dout_En and Dout_Index are rd_valid and rd_addr delayed by one cycle, aligned with the RAM data.
- Dout_Index is 0 whenever Dout_En is 0. It never rests at 62 or 63, because the CP stage keys on those values.
- Simultaneous events: a write completing bank X and a read clearing bank Y in the same cycle are independent. A write into a bank in the cycle its full flag clears is not possible, since Din_Rdy is still low.
- Reset, including mid-symbol:
  - full[1:0]=0, wr_bank=rd_bank=0, wr_cnt=0, FSM=IDLE.
  - Outputs Dout_Re/Dout_Im/Dout_En/Dout_Index/Sat = 0, Din_Rdy = 1 after reset releases.
  - A partial symbol is discarded. RAM contents are not cleared.

## Timing
- Latency: last input transfer (k=63) at cycle T:
  - full set at T+1;
  - rd_addr 0 issued at T+1;
  - Dout_En with Dout_Index 0 at T+2;
  - Dout_Index 63 at T+65.
- Continuous input at one sample per cycle: Din_Rdy stays 1 permanently, because each bank frees exactly when the writer returns to it.
- Back-to-back full banks: output is a contiguous stream with the index wrapping 63→0 and no idle cycle.
- Input gaps (Din_En low) are allowed anywhere. The output burst for a symbol is always 64 consecutive cycles.

## Structure
- Shared package (ofdm_pkg) holds:
  - N_FFT=64, LOG2_N=6;
  - function bitrev6;
  - function sat8 (round, shift, clamp) taking DIN_W and SHIFT.
- Storage: four instances of the existing spram_64, as Re/Im × two banks.
  - Port A: write, with wea = transfer & (wr_bank==b).
  - Port B: read only, with web=0.
  - Output mux is selected by a registered copy of rd_bank.
- No other sub-modules. FSM, counters and flags stay in this file.

## Test plan
- Single symbol, Din_Re = k·64 for input order k=0..63 (SHIFT=6), Din_Im = 0:
  - output at Dout_Index i has Dout_Re = bitrev6(i); e.g. index 1 → 32, index 3 → 48;
  - Dout_En first rises exactly 2 cycles after the last transfer.
- Scaling, SHIFT=6, one sample each:
  - 0x7FFF → 127 with Sat;
  - -32768 → -128 with Sat;
  - 32 → 1;
  - -32 → 0;
  - 95 → 1;
  - 96 → 2;
  - none of the last four asserts Sat.
- Four symbols fed continuously, 256 cycles:
  - Din_Rdy never drops;
  - Dout_En is high for 256 consecutive cycles;
  - Dout_Index wraps 63→0 three times;
  - data matches bitrev per symbol.
- Random Din_En gaps (50% duty) over 3 symbols:
  - each output symbol is a 64-cycle contiguous burst;
  - Dout_Index is 0 between bursts;
  - no data loss.
- Stall check: write bank 0 (rd busy), then hold until both banks full:
  - Din_Rdy = 0 until the first read completes;
  - Din_En asserted while Din_Rdy = 0 writes nothing.
- rst_n low for one cycle after 30 samples:
  - no output burst;
  - the next full symbol outputs correctly with bank 0 first.

Source files
------------

// File: rtl/ofdm_pkg.sv
// Shared OFDM constants and helpers: bit reversal and sample scaling.
package ofdm_pkg;

    localparam int N_FFT  = 64;
    localparam int LOG2_N = 6;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_e;

    typedef struct packed {
        logic [7:0] val;
        logic       sat;
    } sat8_t;

    // Mirror a 6-bit address (FFT bin order <-> natural order).
    function automatic logic [5:0] bitrev6(input logic [5:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) begin
            r[i] = a[5-i];
        end
        return r;
    endfunction

    // Round half up, arithmetic shift by 'shift', clamp to signed 8 bits.
    // x holds a din_w-bit signed value; the sum is formed one bit wider
    // than the input so the rounding constant can never overflow.
    function automatic sat8_t sat8(input logic signed [31:0] x,
                                   input int din_w,
                                   input int shift);
        logic signed [31:0] xs;
        logic signed [32:0] sum;
        logic signed [32:0] y;
        sat8_t              r;
        xs  = x <<< (32 - din_w);
        xs  = xs >>> (32 - din_w);
        sum = {xs[31], xs} + (33'sd1 <<< (shift - 1));
        y   = sum >>> shift;
        if (y > 33'sd127) begin
            r.val = 8'h7F;
            r.sat = 1'b1;
        end else if (y < -33'sd128) begin
            r.val = 8'h80;
            r.sat = 1'b1;
        end else begin
            r.val = y[7:0];
            r.sat = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/spram_64.sv
// 64 x 8 RAM: port A writes, port B reads (or writes) with a one-cycle
// registered read. Contents are not reset.
module spram_64 (
    input  logic       clk,
    input  logic       wea,
    input  logic [5:0] addra,
    input  logic [7:0] dina,
    input  logic       web,
    input  logic [5:0] addrb,
    input  logic [7:0] dinb,
    output logic [7:0] doutb
);

    logic [7:0] mem [64];

    // Array writes from either port plus the registered port-B read.
    always_ff @(posedge clk) begin
        if (wea) begin
            mem[addra] <= dina;
        end
        if (web) begin
            mem[addrb] <= dinb;
        end
        doutb <= mem[addrb];
    end

endmodule

// File: rtl/ifft_reorder.sv
// IFFT output reorder: scales bit-reversed samples to 8 bits, stores each
// 64-sample symbol in one half of a ping-pong buffer and replays it in
// natural order as a contiguous indexed burst for the CP inserter.
module ifft_reorder
    import ofdm_pkg::*;
#(
    parameter int DIN_W = 16,
    parameter int SHIFT = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DIN_W-1:0] Din_Re,
    input  logic [DIN_W-1:0] Din_Im,
    input  logic             Din_En,
    output logic             Din_Rdy,
    output logic [7:0]       Dout_Re,
    output logic [7:0]       Dout_Im,
    output logic             Dout_En,
    output logic [5:0]       Dout_Index,
    output logic             Sat
);

    rd_state_e  state_q, state_d;
    logic [1:0] full_q, full_d;
    logic       wr_bank_q, wr_bank_d;
    logic       rd_bank_q, rd_bank_d;
    logic [5:0] wr_cnt_q, wr_cnt_d;
    logic [5:0] rd_cnt_q, rd_cnt_d;
    logic       rd_sel_q, rd_sel_d;
    logic       dout_en_q, dout_en_d;
    logic [5:0] dout_index_q, dout_index_d;
    logic       sat_q, sat_d;

    sat8_t      re_sc_s, im_sc_s;
    logic       din_rdy_s, xfer_s, wr_done_s, rd_done_s, rd_valid_s;
    logic [5:0] wr_addr_s, rd_addr_s;
    logic [7:0] ram_re_s [2];
    logic [7:0] ram_im_s [2];

    // Input scaling and transfer qualification; ready depends only on flops.
    always_comb begin
        re_sc_s   = sat8(32'(signed'(Din_Re)), DIN_W, SHIFT);
        im_sc_s   = sat8(32'(signed'(Din_Im)), DIN_W, SHIFT);
        din_rdy_s = ~full_q[wr_bank_q];
        xfer_s    = Din_En & din_rdy_s;
        wr_addr_s = bitrev6(wr_cnt_q);
    end

    // Write counter and bank toggle on the 64th accepted sample.
    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        wr_done_s = 1'b0;
        if (xfer_s) begin
            if (wr_cnt_q == 6'd63) begin
                wr_cnt_d  = 6'd0;
                wr_bank_d = ~wr_bank_q;
                wr_done_s = 1'b1;
            end else begin
                wr_cnt_d = wr_cnt_q + 6'd1;
            end
        end else begin
            wr_cnt_d = wr_cnt_q;
        end
    end

    // Reader next state: IDLE issues address 0 as soon as a bank is full,
    // RUN walks the remaining addresses and chains straight into the
    // other bank when it is already full.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_done_s = 1'b0;
        case (state_q)
            RD_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d  = RD_RUN;
                    rd_cnt_d = 6'd1;
                end else begin
                    rd_cnt_d = 6'd0;
                end
            end
            RD_RUN: begin
                rd_cnt_d = rd_cnt_q + 6'd1;
                if (rd_cnt_q == 6'd63) begin
                    rd_done_s = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                    if (full_q[~rd_bank_q]) begin
                        state_d = RD_RUN;
                    end else begin
                        state_d = RD_IDLE;
                    end
                end else begin
                    state_d = RD_RUN;
                end
            end
            default: begin
                state_d  = RD_IDLE;
                rd_cnt_d = 6'd0;
            end
        endcase
    end

    // Reader outputs: read strobe and address presented to the RAMs.
    always_comb begin
        rd_valid_s = 1'b0;
        rd_addr_s  = 6'd0;
        case (state_q)
            RD_IDLE: begin
                rd_valid_s = full_q[rd_bank_q];
                rd_addr_s  = 6'd0;
            end
            RD_RUN: begin
                rd_valid_s = 1'b1;
                rd_addr_s  = rd_cnt_q;
            end
            default: begin
                rd_valid_s = 1'b0;
                rd_addr_s  = 6'd0;
            end
        endcase
    end

    // Bank-full flags plus output pipeline aligned with the RAM read.
    always_comb begin
        full_d = full_q;
        if (rd_done_s) begin
            full_d[rd_bank_q] = 1'b0;
        end else begin
            full_d = full_q;
        end
        if (wr_done_s) begin
            full_d[wr_bank_q] = 1'b1;
        end else begin
            full_d[wr_bank_q] = full_d[wr_bank_q];
        end
        rd_sel_d     = rd_bank_q;
        dout_en_d    = rd_valid_s;
        dout_index_d = rd_valid_s ? rd_addr_s : 6'd0;
        sat_d        = xfer_s & (re_sc_s.sat | im_sc_s.sat);
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RD_IDLE;
            full_q       <= 2'b00;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_cnt_q     <= 6'd0;
            rd_cnt_q     <= 6'd0;
            rd_sel_q     <= 1'b0;
            dout_en_q    <= 1'b0;
            dout_index_q <= 6'd0;
            sat_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            wr_cnt_q     <= wr_cnt_d;
            rd_cnt_q     <= rd_cnt_d;
            rd_sel_q     <= rd_sel_d;
            dout_en_q    <= dout_en_d;
            dout_index_q <= dout_index_d;
            sat_q        <= sat_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        spram_64 u_ram_re (
            .clk   (clk),
            .wea   (xfer_s & (wr_bank_q == 1'(b))),
            .addra (wr_addr_s),
            .dina  (re_sc_s.val),
            .web   (1'b0),
            .addrb (rd_addr_s),
            .dinb  (8'd0),
            .doutb (ram_re_s[b])
        );
        spram_64 u_ram_im (
            .clk   (clk),
            .wea   (xfer_s & (wr_bank_q == 1'(b))),
            .addra (wr_addr_s),
            .dina  (im_sc_s.val),
            .web   (1'b0),
            .addrb (rd_addr_s),
            .dinb  (8'd0),
            .doutb (ram_im_s[b])
        );
    end

    // RAM contents are not reset, so data is forced to zero outside bursts.
    always_comb begin
        Din_Rdy    = din_rdy_s;
        Dout_En    = dout_en_q;
        Dout_Index = dout_index_q;
        Sat        = sat_q;
        if (dout_en_q) begin
            Dout_Re = ram_re_s[rd_sel_q];
            Dout_Im = ram_im_s[rd_sel_q];
        end else begin
            Dout_Re = 8'd0;
            Dout_Im = 8'd0;
        end
    end

endmodule
